// File: rtl/lcd_pkg.sv
// Shared HD44780 command constants, driver state encoding and init-list ROM.
// Imported by the LCD bus driver and the calculator display sequencer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_DDRAM_L1  = 8'h80;
  localparam logic [7:0] LCD_DDRAM_L2  = 8'hC0;

  localparam int unsigned INIT_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_EN_HI,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  // Byte currently presented on the LCD bus.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  function automatic logic [7:0] init_cmd(input logic [INIT_IDX_W-1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_8B2L;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_CLEAR;
      default: cmd = LCD_ENTRY_INC;
    endcase
    return cmd;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic needs_long_wait(input lcd_byte_t b);
    return !b.rs && (b.data[7:2] == 6'd0) && (b.data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Upstream byte handshake plus the LCD-side bus of the character LCD driver.
interface lcd_bus_driver_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       init_done;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, init_done, busy, lcd_data, lcd_rs, lcd_rw, lcd_en
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, init_done, busy, lcd_data, lcd_rs, lcd_rw, lcd_en
  );

endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done_c is high once the loaded cycle count has elapsed.
module lcd_delay_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cyc,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;

  // Loading N keeps done_c low for N-1 cycles, so the owning state lasts N cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(RST_CYC - 1);
    end else if (load) begin
      cnt_q <= load_cyc - CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write controller: power-up init, then one handshaked byte per
// SETUP / EN pulse / execution-wait cycle.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 2_000_000,
  parameter int unsigned SETUP_CYC      = 25,
  parameter int unsigned EN_HIGH_CYC    = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2_500,
  parameter int unsigned CLEAR_WAIT_CYC = 100_000
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_bus_driver_if.slave   bus
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
  localparam int unsigned MAX_B   = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > CLEAR_WAIT_CYC) ? MAX_AB : CLEAR_WAIT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(3);

  lcd_state_e              state_q, state_d;
  lcd_byte_t               cur_q, cur_d;
  logic                    en_q, en_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    init_done_q, init_done_d;
  logic [INIT_IDX_W-1:0]   idx_q, idx_d;
  logic                    tmr_load_c;
  logic [CNT_W-1:0]        tmr_cyc_c;
  logic                    tmr_done_c;

  lcd_delay_timer #(
    .CNT_W   (CNT_W),
    .RST_CYC (POWERUP_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .load_cyc (tmr_cyc_c),
    .done_c   (tmr_done_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP;
      cur_q       <= '0;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    en_d        = en_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    idx_d       = idx_q;
    tmr_load_c  = 1'b0;
    tmr_cyc_c   = '0;

    unique case (state_q)
      ST_PWRUP: begin
        if (tmr_done_c) begin
          state_d    = ST_SETUP;
          cur_d      = '{rs: 1'b0, data: init_cmd(idx_q)};
          tmr_load_c = 1'b1;
          tmr_cyc_c  = CNT_W'(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (tmr_done_c) begin
          state_d    = ST_EN_HI;
          en_d       = 1'b1;
          tmr_load_c = 1'b1;
          tmr_cyc_c  = CNT_W'(EN_HIGH_CYC);
        end
      end
      ST_EN_HI: begin
        if (tmr_done_c) begin
          state_d    = ST_WAIT;
          en_d       = 1'b0;
          tmr_load_c = 1'b1;
          tmr_cyc_c  = needs_long_wait(cur_q) ? CNT_W'(CLEAR_WAIT_CYC) : CNT_W'(CMD_WAIT_CYC);
        end
      end
      ST_WAIT: begin
        if (tmr_done_c) begin
          // During init, chain straight into the next list entry.
          if (init_done_q || (idx_q == INIT_LAST)) begin
            state_d     = ST_IDLE;
            ready_d     = 1'b1;
            busy_d      = 1'b0;
            init_done_d = 1'b1;
          end else begin
            state_d    = ST_SETUP;
            idx_d      = idx_q + INIT_IDX_W'(1);
            cur_d      = '{rs: 1'b0, data: init_cmd(idx_q + INIT_IDX_W'(1))};
            tmr_load_c = 1'b1;
            tmr_cyc_c  = CNT_W'(SETUP_CYC);
          end
        end
      end
      ST_IDLE: begin
        if (bus.in_valid && ready_q) begin
          state_d    = ST_SETUP;
          cur_d      = '{rs: bus.in_rs, data: bus.in_data};
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          tmr_load_c = 1'b1;
          tmr_cyc_c  = CNT_W'(SETUP_CYC);
        end
      end
      default: begin
        state_d = ST_PWRUP;
      end
    endcase
  end

  assign bus.in_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done_q;
  assign bus.lcd_data  = cur_q.data;
  assign bus.lcd_rs    = cur_q.rs;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_en    = en_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with shortened timing parameters.
module tb_lcd_bus_driver;

  localparam int unsigned P  = 100;
  localparam int unsigned S  = 2;
  localparam int unsigned E  = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned LW = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lcd_bus_driver_if bus ();

  lcd_bus_driver #(
    .POWERUP_CYC    (P),
    .SETUP_CYC      (S),
    .EN_HIGH_CYC    (E),
    .CMD_WAIT_CYC   (CW),
    .CLEAR_WAIT_CYC (LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results of the init-sequence observer.
  int         rise_n[4];
  int         fall_n[4];
  logic [7:0] rise_data[4];
  logic       rise_rs[4];
  int         npulse;
  int         idle_n;
  int         pwrup_bad;

  // Expected init sequence, edges counted from the last reset edge.
  int         exp_rise[4] = '{102, 118, 134, 180};
  int         exp_fall[4] = '{106, 122, 138, 184};
  logic [7:0] exp_data[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  localparam int EXP_IDLE = 194;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watches edges after reset until in_ready rises; optionally waves 0x41 early on.
  task automatic observe_init(input int valid_until);
    logic prev;
    prev      = 1'b0;
    npulse    = 0;
    idle_n    = -1;
    pwrup_bad = 0;
    for (int i = 0; i < 4; i++) begin
      rise_n[i] = -1; fall_n[i] = -1; rise_data[i] = 8'h00; rise_rs[i] = 1'b1;
    end
    for (int n = 1; n <= 400 && idle_n < 0; n++) begin
      if (n < valid_until) begin
        bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'h41;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (n < int'(P) && (bus.lcd_en || bus.in_ready || bus.lcd_data != 8'h00)) pwrup_bad++;
      if (bus.lcd_en && !prev) begin
        if (npulse < 4) begin
          rise_n[npulse] = n; rise_data[npulse] = bus.lcd_data; rise_rs[npulse] = bus.lcd_rs;
        end
        npulse++;
      end
      if (!bus.lcd_en && prev && npulse >= 1 && npulse <= 4) fall_n[npulse-1] = n;
      if (bus.in_ready) idle_n = n;
      prev = bus.lcd_en;
    end
    bus.in_valid = 1'b0;
  endtask

  // Issues one byte from IDLE and measures the resulting bus waveform (edge k = 0).
  task automatic observe_write(input logic rs, input logic [7:0] data,
                               output int en_rise, output int en_fall, output int ready_n,
                               output int hold_bad, output int pulses);
    logic prev;
    bus.in_valid = 1'b1; bus.in_rs = rs; bus.in_data = data;
    step();
    bus.in_valid = 1'b0; bus.in_rs = ~rs; bus.in_data = ~data;
    en_rise = -1; en_fall = -1; ready_n = -1; hold_bad = 0; pulses = 0; prev = 1'b0;
    for (int n = 0; n <= 200 && ready_n < 0; n++) begin
      if (n > 0) step();
      if (bus.lcd_rs !== rs || bus.lcd_data !== data) hold_bad++;
      if (bus.lcd_en && !prev) begin
        pulses++;
        if (en_rise < 0) en_rise = n;
      end
      if (!bus.lcd_en && prev && en_fall < 0) en_fall = n;
      if (bus.in_ready) ready_n = n;
      prev = bus.lcd_en;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_rs = 1'b0; bus.in_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (bus.lcd_en !== 1'b0) begin errors++; $display("FAIL reset_lcd_en got %0b want 0", bus.lcd_en); end
    checks++; if (bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_lcd_rs got %0b want 0", bus.lcd_rs); end
    checks++; if (bus.lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_lcd_rw got %0b want 0", bus.lcd_rw); end
    checks++; if (bus.lcd_data !== 8'h00) begin errors++; $display("FAIL reset_lcd_data got %02h want 00", bus.lcd_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", bus.busy); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %0b want 0", bus.init_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    observe_init(90);
    $display("init sequence: first IDLE cycle at edge %0d after reset", idle_n);
    checks++; if (pwrup_bad !== 0) begin errors++; $display("FAIL init_pwrup_quiet bad cycles %0d want 0", pwrup_bad); end
    checks++; if (npulse !== 4) begin errors++; $display("FAIL init_pulse_count got %0d want 4", npulse); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rise_n[i] !== exp_rise[i]) begin errors++; $display("FAIL init_rise%0d got %0d want %0d", i, rise_n[i], exp_rise[i]); end
      checks++; if (fall_n[i] !== exp_fall[i]) begin errors++; $display("FAIL init_fall%0d got %0d want %0d", i, fall_n[i], exp_fall[i]); end
      checks++; if (rise_data[i] !== exp_data[i]) begin errors++; $display("FAIL init_data%0d got %02h want %02h", i, rise_data[i], exp_data[i]); end
      checks++; if (rise_rs[i] !== 1'b0) begin errors++; $display("FAIL init_rs%0d got %0b want 0", i, rise_rs[i]); end
    end
    checks++; if (idle_n !== EXP_IDLE) begin errors++; $display("FAIL init_idle_edge got %0d want %0d", idle_n, EXP_IDLE); end
    checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done got %0b want 1", bus.init_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL init_busy got %0b want 0", bus.busy); end
  endtask

  task automatic test_single_char();
    int r, f, rdy, hb, pc;
    observe_write(1'b1, 8'h35, r, f, rdy, hb, pc);
    checks++; if (r !== 2) begin errors++; $display("FAIL char_en_rise got %0d want 2", r); end
    checks++; if (f !== 6) begin errors++; $display("FAIL char_en_fall got %0d want 6", f); end
    checks++; if (rdy !== 16) begin errors++; $display("FAIL char_ready got %0d want 16", rdy); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL char_hold bad cycles %0d want 0", hb); end
    checks++; if (pc !== 1) begin errors++; $display("FAIL char_pulses got %0d want 1", pc); end
  endtask

  task automatic test_clear();
    int r, f, rdy, hb, pc;
    observe_write(1'b0, 8'h01, r, f, rdy, hb, pc);
    checks++; if (f !== 6) begin errors++; $display("FAIL clear_en_fall got %0d want 6", f); end
    checks++; if (rdy - f !== 40) begin errors++; $display("FAIL clear_wait got %0d want 40", rdy - f); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL clear_hold bad cycles %0d want 0", hb); end
  endtask

  // Boundary cases of the long/short wait decision.
  task automatic test_wait_select();
    logic       t_rs[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] t_data[5] = '{8'h02, 8'h03, 8'h04, 8'h01, 8'h00};
    int         t_rdy[5]  = '{46, 46, 16, 16, 16};
    int r, f, rdy, hb, pc;
    for (int i = 0; i < 5; i++) begin
      observe_write(t_rs[i], t_data[i], r, f, rdy, hb, pc);
      checks++;
      if (rdy !== t_rdy[i]) begin
        errors++;
        $display("FAIL wait_sel rs=%0b data=%02h ready got %0d want %0d", t_rs[i], t_data[i], rdy, t_rdy[i]);
      end
    end
  endtask

  task automatic test_ignore_en_hi();
    int   data_bad, pulses, rdy;
    logic prev;
    bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'h42;
    step();
    bus.in_valid = 1'b0;
    data_bad = 0; pulses = 0; rdy = -1; prev = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      step();
      if (bus.lcd_data !== 8'h42) data_bad++;
      if (bus.lcd_en && !prev) pulses++;
      if (bus.in_ready && rdy < 0) rdy = n;
      prev = bus.lcd_en;
      if (n == 3) begin bus.in_valid = 1'b1; bus.in_data = 8'h41; end
      if (n == 5) bus.in_valid = 1'b0;
    end
    checks++; if (data_bad !== 0) begin errors++; $display("FAIL en_hi_ignore data bad cycles %0d want 0", data_bad); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL en_hi_ignore pulses got %0d want 1", pulses); end
    checks++; if (rdy !== 16) begin errors++; $display("FAIL en_hi_ignore ready got %0d want 16", rdy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL en_hi_ignore idle got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int         pulses, rdy1, rdy2, acc2;
    int         p_n[2];
    logic [7:0] p_data[2];
    logic       p_rs[2];
    logic       prev;
    bus.in_valid = 1'b1; bus.in_rs = 1'b0; bus.in_data = 8'hC0;
    step();
    bus.in_rs = 1'b1; bus.in_data = 8'h2D;
    pulses = 0; rdy1 = -1; rdy2 = -1; acc2 = -1; prev = 1'b0;
    for (int i = 0; i < 2; i++) begin p_n[i] = -1; p_data[i] = 8'h00; p_rs[i] = 1'bx; end
    for (int n = 1; n <= 60; n++) begin
      step();
      if (bus.lcd_en && !prev) begin
        if (pulses < 2) begin p_n[pulses] = n; p_data[pulses] = bus.lcd_data; p_rs[pulses] = bus.lcd_rs; end
        pulses++;
      end
      prev = bus.lcd_en;
      if (bus.in_ready && rdy1 < 0) rdy1 = n;
      if (acc2 >= 0 && bus.in_ready && rdy2 < 0) rdy2 = n;
      if (acc2 < 0 && bus.lcd_data === 8'h2D) begin acc2 = n; bus.in_valid = 1'b0; end
    end
    bus.in_valid = 1'b0;
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    checks++; if (rdy1 !== 16) begin errors++; $display("FAIL b2b_ready1 got %0d want 16", rdy1); end
    checks++; if (acc2 !== 17) begin errors++; $display("FAIL b2b_accept2 got %0d want 17", acc2); end
    checks++; if (rdy2 !== 33) begin errors++; $display("FAIL b2b_ready2 got %0d want 33", rdy2); end
    checks++; if (p_n[1] !== 19) begin errors++; $display("FAIL b2b_rise2 got %0d want 19", p_n[1]); end
    checks++; if (p_data[0] !== 8'hC0 || p_rs[0] !== 1'b0) begin errors++; $display("FAIL b2b_byte1 got rs=%0b %02h want rs=0 C0", p_rs[0], p_data[0]); end
    checks++; if (p_data[1] !== 8'h2D || p_rs[1] !== 1'b1) begin errors++; $display("FAIL b2b_byte2 got rs=%0b %02h want rs=1 2D", p_rs[1], p_data[1]); end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'h35;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    checks++; if (bus.lcd_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_en got %0b want 1", bus.lcd_en); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (bus.lcd_en !== 1'b0) begin errors++; $display("FAIL midrst_en got %0b want 0", bus.lcd_en); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done got %0b want 0", bus.init_done); end
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_handshake got ready=%0b busy=%0b want 0/1", bus.in_ready, bus.busy); end
    checks++; if (bus.lcd_data !== 8'h00 || bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL midrst_bus got rs=%0b %02h want rs=0 00", bus.lcd_rs, bus.lcd_data); end
    observe_init(0);
    checks++; if (npulse !== 4) begin errors++; $display("FAIL midrst_pulses got %0d want 4", npulse); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rise_n[i] !== exp_rise[i] || rise_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL midrst_init%0d got edge %0d data %02h want edge %0d data %02h", i, rise_n[i], rise_data[i], exp_rise[i], exp_data[i]);
      end
    end
    checks++; if (idle_n !== EXP_IDLE) begin errors++; $display("FAIL midrst_idle got %0d want %0d", idle_n, EXP_IDLE); end
    checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL midrst_done got %0b want 1", bus.init_done); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_char();
    test_clear();
    test_wait_select();
    test_ignore_en_hi();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
